// File: rtl/sprite_pkg.sv
// Shared defaults, colour type and index-mirroring helper for the sprite object.
package sprite_pkg;

   localparam int COORD_W_DEF = 10;
   localparam int COLOR_W_DEF = 24;

   typedef logic [COLOR_W_DEF-1:0] colour_t;

   // Mirror an index inside a sprite of edge 'size' when flip is set.
   function automatic logic [31:0] mirror_idx(input logic [31:0] idx,
                                              input logic [31:0] size,
                                              input logic        flip);
      return flip ? (size - 32'd1 - idx) : idx;
   endfunction

endpackage

// File: rtl/sprite_pixel_ram.sv
// Sprite colour store: one write port, one synchronous read-first read port.
module sprite_pixel_ram #(
   parameter  int DEPTH = 256,
   parameter  int WIDTH = 24,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Write and registered read in one block; a same-address collision returns the old word.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sprite_obj_param.sv
// Parametrised sprite object: SIZE x SIZE colour sprite with opaque mask,
// frame-synchronous position/flip shadowing and a fixed 2-cycle pixel pipeline.
module sprite_obj_param
   import sprite_pkg::*;
#(
   parameter  int SIZE    = 16,
   parameter  int COORD_W = COORD_W_DEF,
   parameter  int COLOR_W = COLOR_W_DEF,
   localparam int AW      = $clog2(SIZE*SIZE)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] hdmi_x,
   input  logic [COORD_W-1:0] hdmi_y,
   input  logic               pix_valid,
   input  logic               frame_start,
   input  logic               active,
   input  logic               pos_wr,
   input  logic [COORD_W-1:0] pos_x,
   input  logic [COORD_W-1:0] pos_y,
   input  logic               flip_h,
   input  logic               flip_v,
   input  logic               pix_wr,
   input  logic [AW-1:0]      pix_addr,
   input  logic [COLOR_W-1:0] pix_color,
   input  logic               pix_opaque,
   output logic               out_valid,
   output logic               present,
   output logic [COLOR_W-1:0] out_color
);

   localparam int LW    = $clog2(SIZE);
   localparam int DEPTH = SIZE*SIZE;

   logic [COORD_W-1:0] r_sh_x, r_sh_y, r_lv_x, r_lv_y;
   logic               r_sh_fh, r_sh_fv, r_lv_fh, r_lv_fv, r_pend;

   logic [COORD_W:0]   w_x_end, w_y_end;
   logic               w_in_x, w_in_y;
   logic [LW-1:0]      w_dx, w_dy, w_col, w_row;
   logic [AW-1:0]      w_addr;

   logic               r_vld_p1, r_hit_p1;
   logic [AW-1:0]      r_addr_p1;
   logic [DEPTH-1:0]   r_opaque;
   logic               r_vld_p2, r_present_p2;
   logic [COLOR_W-1:0] w_ram_rdata;

   // Shadow capture on pos_wr; shadow promotes to live only at a frame start while pending.
   // A pos_wr on the frame-start cycle lands in the shadow and waits for the next frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sh_x  <= '0;
         r_sh_y  <= '0;
         r_sh_fh <= 1'b0;
         r_sh_fv <= 1'b0;
         r_lv_x  <= '0;
         r_lv_y  <= '0;
         r_lv_fh <= 1'b0;
         r_lv_fv <= 1'b0;
         r_pend  <= 1'b0;
      end else begin
         if (frame_start && r_pend) begin
            r_lv_x  <= r_sh_x;
            r_lv_y  <= r_sh_y;
            r_lv_fh <= r_sh_fh;
            r_lv_fv <= r_sh_fv;
            r_pend  <= 1'b0;
         end
         if (pos_wr) begin
            r_sh_x  <= pos_x;
            r_sh_y  <= pos_y;
            r_sh_fh <= flip_h;
            r_sh_fv <= flip_v;
            r_pend  <= 1'b1;
         end
      end
   end

   // Box ends carry an extra bit so a sprite hanging off the right/bottom edge clips instead of wrapping.
   assign w_x_end = {1'b0, r_lv_x} + (COORD_W+1)'(SIZE);
   assign w_y_end = {1'b0, r_lv_y} + (COORD_W+1)'(SIZE);
   assign w_in_x  = (hdmi_x >= r_lv_x) && ({1'b0, hdmi_x} < w_x_end);
   assign w_in_y  = (hdmi_y >= r_lv_y) && ({1'b0, hdmi_y} < w_y_end);
   assign w_dx    = LW'(hdmi_x - r_lv_x);
   assign w_dy    = LW'(hdmi_y - r_lv_y);
   assign w_col   = LW'(mirror_idx(32'(w_dx), 32'(SIZE), r_lv_fh));
   assign w_row   = LW'(mirror_idx(32'(w_dy), 32'(SIZE), r_lv_fv));
   assign w_addr  = {w_row, w_col};

   // Stage 1: register hit, valid and sprite address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_p1 <= 1'b0;
         r_hit_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= pix_valid;
         r_hit_p1 <= w_in_x & w_in_y & active & pix_valid;
      end
      r_addr_p1 <= w_addr;
   end

   // Opaque mask kept in flops so reset clears every pixel to transparent.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_opaque <= '0;
      end else if (pix_wr) begin
         r_opaque[pix_addr] <= pix_opaque;
      end
   end

   // Stage 2: read-first lookup of the opaque bit alongside the colour RAM read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_p2     <= 1'b0;
         r_present_p2 <= 1'b0;
      end else begin
         r_vld_p2     <= r_vld_p1;
         r_present_p2 <= r_hit_p1 & r_opaque[r_addr_p1];
      end
   end

   sprite_pixel_ram #(
      .DEPTH (DEPTH),
      .WIDTH (COLOR_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (pix_wr),
      .i_waddr (pix_addr),
      .i_wdata (pix_color),
      .i_raddr (r_addr_p1),
      .o_rdata (w_ram_rdata)
   );

   assign out_valid = r_vld_p2;
   assign present   = r_present_p2;
   assign out_color = r_present_p2 ? w_ram_rdata : '0;

endmodule

// File: tb/tb_sprite_obj_param.sv
// Bench for sprite_obj_param: directed scenarios plus randomized traffic against a behavioural model.
module tb_sprite_obj_param;
   import sprite_pkg::*;

   localparam int SIZE    = 16;
   localparam int COORD_W = 10;
   localparam int COLOR_W = 24;
   localparam int AW      = $clog2(SIZE*SIZE);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic [COORD_W-1:0] hdmi_x, hdmi_y, pos_x, pos_y;
   logic               pix_valid, frame_start, active, pos_wr, flip_h, flip_v;
   logic               pix_wr, pix_opaque;
   logic [AW-1:0]      pix_addr;
   colour_t            pix_color;
   logic               out_valid, present;
   colour_t            out_color;

   sprite_obj_param #(.SIZE(SIZE), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) dut (
      .clk(clk), .rst_n(rst_n), .hdmi_x(hdmi_x), .hdmi_y(hdmi_y),
      .pix_valid(pix_valid), .frame_start(frame_start), .active(active),
      .pos_wr(pos_wr), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h), .flip_v(flip_v),
      .pix_wr(pix_wr), .pix_addr(pix_addr), .pix_color(pix_color), .pix_opaque(pix_opaque),
      .out_valid(out_valid), .present(present), .out_color(out_color)
   );

   typedef struct packed {
      logic    v;
      logic    p;
      colour_t c;
   } res_t;

   res_t    exp_q[$];
   res_t    prev_res = '0;
   res_t    last_exp = '0;
   int      n_checks = 0;
   int      n_fail   = 0;

   // Reference state: screen-space position ints, plain arrays for the sprite.
   int      m_sx, m_sy, m_lx, m_ly;
   bit      m_sfh, m_sfv, m_lfh, m_lfv, m_pend;
   bit      m_opq [SIZE*SIZE];
   colour_t m_col [SIZE*SIZE];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // What the sprite shows for the pixel on the inputs right now.
   function automatic res_t model_pixel();
      res_t r;
      int dx, dy, col, row, a;
      r   = '0;
      r.v = pix_valid;
      dx  = int'(hdmi_x) - m_lx;
      dy  = int'(hdmi_y) - m_ly;
      if (dx >= 0 && dx < SIZE && dy >= 0 && dy < SIZE && active && pix_valid) begin
         col = m_lfh ? SIZE - 1 - dx : dx;
         row = m_lfv ? SIZE - 1 - dy : dy;
         a   = row * SIZE + col;
         if (m_opq[a]) begin
            r.p = 1'b1;
            r.c = m_col[a];
         end
      end
      return r;
   endfunction

   // One clock: update reference, queue the output expected after this edge, advance.
   task automatic tick();
      res_t r, e;
      if (!rst_n) begin
         r = '0;
         e = '0;
         m_sx = 0; m_sy = 0; m_lx = 0; m_ly = 0;
         m_sfh = 0; m_sfv = 0; m_lfh = 0; m_lfv = 0; m_pend = 0;
         for (int i = 0; i < SIZE*SIZE; i++) m_opq[i] = 1'b0;
      end else begin
         if (pix_wr) begin
            m_opq[pix_addr] = pix_opaque;
            m_col[pix_addr] = pix_color;
         end
         r = model_pixel();
         e = prev_res;
         if (frame_start && m_pend) begin
            m_lx = m_sx; m_ly = m_sy; m_lfh = m_sfh; m_lfv = m_sfv; m_pend = 0;
         end
         if (pos_wr) begin
            m_sx = int'(pos_x); m_sy = int'(pos_y); m_sfh = flip_h; m_sfv = flip_v; m_pend = 1;
         end
      end
      prev_res = r;
      last_exp = e;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      pix_wr      = 1'b0;
      pos_wr      = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic set_pos(input int x, input int y, input logic fh, input logic fv);
      pos_x = COORD_W'(x); pos_y = COORD_W'(y); flip_h = fh; flip_v = fv;
      pos_wr = 1'b1;
      tick();
      frame_start = 1'b1;
      tick();
   endtask

   task automatic wr_pix(input int row, input int col, input colour_t c, input logic o);
      pix_addr = AW'(row * SIZE + col); pix_color = c; pix_opaque = o; pix_wr = 1'b1;
      tick();
   endtask

   task automatic probe(input int x, input int y, input logic ep, input colour_t ec, input string name);
      hdmi_x = COORD_W'(x); hdmi_y = COORD_W'(y); pix_valid = 1'b1; active = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
      check({name, "_model_present"}, 32'(last_exp.p), 32'(ep));
      check({name, "_model_color"},   32'(last_exp.c), 32'(ec));
      check({name, "_present"},       32'(present),    32'(ep));
      check({name, "_color"},         32'(out_color),  32'(ec));
   endtask

   // Per-cycle output comparison against the queued expectation.
   initial begin
      res_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cyc_out_valid", 32'(out_valid), 32'(e.v));
            check("cyc_present",   32'(present),   32'(e.p));
            check("cyc_out_color", 32'(out_color), 32'(e.c));
         end
      end
   end

   initial begin
      rst_n = 1'b0; hdmi_x = '0; hdmi_y = '0; pix_valid = 1'b0; frame_start = 1'b0;
      active = 1'b0; pos_wr = 1'b0; pos_x = '0; pos_y = '0; flip_h = 1'b0; flip_v = 1'b0;
      pix_wr = 1'b0; pix_addr = '0; pix_color = '0; pix_opaque = 1'b0;
      repeat (3) tick();
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_present",   32'(present),   32'd0);
      check("reset_out_color", 32'(out_color), 32'd0);
      rst_n = 1'b1;
      tick();

      // Freshly reset sprite is fully transparent.
      set_pos(100, 50, 1'b0, 1'b0);
      for (int y = 0; y < SIZE; y++) begin
         for (int x = 0; x < SIZE; x++) begin
            hdmi_x = COORD_W'(100 + x); hdmi_y = COORD_W'(50 + y); pix_valid = 1'b1; active = 1'b1;
            tick();
         end
      end
      wr_pix(0, 0, 24'h00FF00, 1'b0);
      probe(100, 50, 1'b0, 24'h0, "transparent");

      // Basic hit and box edge.
      wr_pix(2, 3, 24'hFF0000, 1'b1);
      probe(103, 52, 1'b1, 24'hFF0000, "basic_hit");
      probe(116, 50, 1'b0, 24'h0, "basic_right_edge");

      // Horizontal flip.
      set_pos(100, 50, 1'b1, 1'b0);
      wr_pix(0, 0, 24'h00AB12, 1'b1);
      probe(115, 50, 1'b1, 24'h00AB12, "flip_h_hit");
      probe(100, 50, 1'b0, 24'h0, "flip_h_miss");

      // Shadow timing.
      pos_x = 10'd200; pos_y = 10'd50; flip_h = 1'b0; flip_v = 1'b0; pos_wr = 1'b1;
      tick();
      probe(115, 50, 1'b1, 24'h00AB12, "shadow_old_live");
      probe(200, 50, 1'b0, 24'h0, "shadow_not_yet");
      pos_x = 10'd300; pos_y = 10'd60; pos_wr = 1'b1; frame_start = 1'b1;
      tick();
      probe(200, 50, 1'b1, 24'h00AB12, "shadow_applied");
      probe(300, 60, 1'b0, 24'h0, "shadow_deferred");
      frame_start = 1'b1;
      tick();
      probe(300, 60, 1'b1, 24'h00AB12, "shadow_next_frame");

      // Clipping at the right screen edge.
      set_pos(1020, 0, 1'b0, 1'b0);
      wr_pix(0, 3, 24'h123456, 1'b1);
      for (int c = 4; c < 8; c++) wr_pix(0, c, 24'h777777, 1'b1);
      probe(1023, 0, 1'b1, 24'h123456, "clip_hit");
      probe(0, 0, 1'b0, 24'h0, "clip_nowrap0");
      probe(3, 0, 1'b0, 24'h0, "clip_nowrap3");

      // Write colliding with the read of the same address.
      hdmi_x = 10'd1023; hdmi_y = 10'd0; pix_valid = 1'b1; active = 1'b1;
      tick();
      pix_valid = 1'b0;
      pix_addr = AW'(3); pix_color = 24'hABCDEF; pix_opaque = 1'b1; pix_wr = 1'b1;
      tick();
      check("collide_model_old", 32'(last_exp.c), 32'h123456);
      check("collide_old_color", 32'(out_color),  32'h123456);
      probe(1023, 0, 1'b1, 24'hABCDEF, "collide_new");

      // Reset pulse in the middle of a line.
      hdmi_x = 10'd1023; hdmi_y = 10'd0; pix_valid = 1'b1; active = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_present",   32'(present),   32'd0);
      pix_valid = 1'b0;
      tick();

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         rst_n       = ($urandom_range(0, 299) != 0);
         pix_wr      = ($urandom_range(0, 2) == 0);
         pix_addr    = AW'($urandom);
         pix_color   = colour_t'($urandom);
         pix_opaque  = ($urandom_range(0, 3) != 0);
         pos_wr      = ($urandom_range(0, 29) == 0);
         pos_x       = ($urandom_range(0, 1) == 0) ? COORD_W'($urandom) : COORD_W'(1008 + $urandom_range(0, 15));
         pos_y       = ($urandom_range(0, 1) == 0) ? COORD_W'($urandom) : COORD_W'(1008 + $urandom_range(0, 15));
         flip_h      = 1'($urandom);
         flip_v      = 1'($urandom);
         frame_start = ($urandom_range(0, 39) == 0);
         active      = ($urandom_range(0, 7) != 0);
         pix_valid   = ($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 9) == 0) begin
            hdmi_x = COORD_W'($urandom);
            hdmi_y = COORD_W'($urandom);
         end else begin
            hdmi_x = COORD_W'(m_lx + int'($urandom_range(0, SIZE + 3)) - 2);
            hdmi_y = COORD_W'(m_ly + int'($urandom_range(0, SIZE + 3)) - 2);
         end
         tick();
      end

      rst_n = 1'b1; pix_valid = 1'b0;
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
